// File: rtl/matrix_operand_streamer_pkg.sv
// Shared constants, state encoding and nibble-select helper for the operand streamer.
package matrix_operand_streamer_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int N_NIBBLES = 8;
  localparam int IDX_W     = 3;
  localparam int FRAME_W   = NIBBLE_W * N_NIBBLES;

  // Index of the final nibble in a frame (B11).
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Frame layout is {B11,B10,B01,B00,A11,A10,A01,A00}, so index k selects bits [4k+3:4k].
  function automatic logic [NIBBLE_W-1:0] frame_nibble(
    input logic [FRAME_W-1:0] frame,
    input logic [IDX_W-1:0]   idx
  );
    return frame[{idx, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/nibble_index_counter.sv
// Nibble index counter: 3-bit up-counter with enable, wraps 7->0 synchronously.
module nibble_index_counter
  import matrix_operand_streamer_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_idx,
  output logic [IDX_W-1:0] o_idx_next
);

  logic [IDX_W-1:0] r_idx;

  // Next index: advance when enabled, returning to 0 after the last nibble.
  always_comb begin
    o_idx_next = r_idx;
    if (i_en) begin
      if (r_idx == LAST_IDX) begin
        o_idx_next = '0;
      end else begin
        o_idx_next = r_idx + 1'b1;
      end
    end
  end

  // Index register, cleared asynchronously so an aborted frame restarts at A00.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx <= '0;
    end else begin
      r_idx <= o_idx_next;
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/matrix_operand_streamer.sv
// Matrix operand streamer: captures two packed 2x2 nibble matrices and feeds them,
// one nibble per cycle, to a serial multiplier after a configurable clear pulse.
// Every output is a register loaded from the next-state decode, so outputs describe
// the state entered at the most recent clock edge.
module matrix_operand_streamer
  import matrix_operand_streamer_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 1  // clear cycles before each frame, 1..4
)
(
  input  logic        clk,
  input  logic        mr,
  input  logic [15:0] mat_a,
  input  logic [15:0] mat_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  output logic [3:0]  i_out,
  output logic        ce_out,
  output logic        clr_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [FRAME_W-1:0]   r_frame;
  logic [1:0]           r_clr_cnt;

  logic                 w_accept;
  logic                 w_idx_en;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_idx_next;

  logic [NIBBLE_W-1:0]  w_i_out_next;
  logic                 w_ce_next;

  logic [NIBBLE_W-1:0]  r_i_out;
  logic                 r_ce;
  logic                 r_clr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_in_ready;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  // The index only moves when a nibble has been offered and the multiplier is not stalling.
  assign w_idx_en = (r_state == ST_STREAM) && !hold;

  nibble_index_counter u_idx (
    .clk        (clk),
    .i_rst      (mr),
    .i_en       (w_idx_en),
    .o_idx      (w_idx),
    .o_idx_next (w_idx_next)
  );

  // Next-state decode; hold is only looked at while streaming.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_state_next = ST_CLEAR;
      ST_CLEAR:  if (r_clr_cnt == CLR_LAST) w_state_next = ST_STREAM;
      ST_STREAM: if (!hold && (w_idx == LAST_IDX)) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Next nibble/enable: the first STREAM cycle always carries A00; afterwards a held
  // cycle repeats the current nibble with ce low, since it was already loaded.
  always_comb begin
    w_i_out_next = '0;
    w_ce_next    = 1'b0;
    if (w_state_next == ST_STREAM) begin
      w_i_out_next = frame_nibble(r_frame, w_idx_next);
      w_ce_next    = (r_state != ST_STREAM) || !hold;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame capture, only on acceptance in IDLE so a busy frame cannot be overwritten.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_frame <= '0;
    end else if (w_accept) begin
      r_frame <= {mat_b, mat_a};
    end
  end

  // Clear-cycle counter: runs only while in CLEAR, parked at 0 elsewhere.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else begin
      r_clr_cnt <= '0;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_i_out    <= '0;
      r_ce       <= 1'b0;
      r_clr      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_i_out    <= w_i_out_next;
      r_ce       <= w_ce_next;
      r_clr      <= (w_state_next == ST_CLEAR);
      r_busy     <= (w_state_next != ST_IDLE);
      r_done     <= (w_state_next == ST_DONE);
      r_in_ready <= (w_state_next == ST_IDLE);
    end
  end

  assign i_out    = r_i_out;
  assign ce_out   = r_ce;
  assign clr_out  = r_clr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign in_ready = r_in_ready;

endmodule
